// File: rtl/uart_tx_async.sv
// UART transmitter: start bit, 7/8 data bits LSB-first, optional parity, stop bit(s), 16x baud enable.
// Optional macro UART_TX_TWO_STOP_EN adds the stop2_i input for a two-stop-bit frame.
module uart_tx_async #(
  parameter int TX_FIFO = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_en_i,
  input  logic       bit8_i,
  input  logic       parity_en_i,
  input  logic       odd_n_even_i,
`ifdef UART_TX_TWO_STOP_EN
  input  logic       stop2_i,
`endif
  input  logic       wen_i,
  input  logic [7:0] data_in_i,
  input  logic       fifo_empty_i,
  output logic       fifo_rd_o,
  output logic       txrdy_o,
  output logic       tx_busy_o,
  output logic       tx_o
);

  // state    | meaning
  // S_IDLE   | line idle, waiting for a full hold register
  // S_START  | driving the start bit
  // S_DATA   | shifting data bits out LSB-first
  // S_PARITY | driving the parity bit
  // S_STOP   | driving the stop bit(s)
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  smp_q, smp_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        fifo_rd_q, fifo_rd_d;
  logic        tx_q, tx_d;
  logic        bit8_q, bit8_d;
  logic        par_en_q, par_en_d;
  logic        par_q, par_d;

  logic        boundary;
  logic        stop_last;
  logic        transfer;
  logic        hold_load;
  logic [7:0]  par_mask;

  assign boundary = baud_en_i && (smp_q == 4'd15);

`ifdef UART_TX_TWO_STOP_EN
  logic stop2_q;
  logic stop_second_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop2_q       <= 1'b0;
      stop_second_q <= 1'b0;
    end else if (transfer) begin
      stop2_q       <= stop2_i;
      stop_second_q <= 1'b0;
    end else if (state_q == S_STOP && boundary && !stop_last) begin
      stop_second_q <= 1'b1;
    end
  end

  assign stop_last = !stop2_q || stop_second_q;
`else
  assign stop_last = 1'b1;
`endif

  // A transfer fires from IDLE on any enable, or straight out of the final stop boundary.
  assign transfer = hold_full_q && baud_en_i &&
                    ((state_q == S_IDLE) || (state_q == S_STOP && boundary && stop_last));

  assign hold_load = (TX_FIFO != 0) ? fifo_rd_q : (wen_i && !hold_full_q);
  assign par_mask  = bit8_i ? 8'hFF : 8'h7F;

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    fifo_rd_d   = 1'b0;
    if (transfer) begin
      hold_full_d = 1'b0;
    end else if (hold_load) begin
      hold_d      = data_in_i;
      hold_full_d = 1'b1;
    end
    if (TX_FIFO != 0) begin
      fifo_rd_d = (state_q == S_IDLE) && !fifo_empty_i && !hold_full_q && !fifo_rd_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    smp_d    = smp_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    bit8_d   = bit8_q;
    par_en_d = par_en_q;
    par_d    = par_q;

    if (state_q != S_IDLE && baud_en_i) begin
      smp_d = smp_q + 4'd1;
    end

    case (state_q)
      S_IDLE: ;
      S_START: begin
        if (boundary) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (boundary) begin
          if (bit_q == (bit8_q ? 3'd7 : 3'd6)) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      S_PARITY: begin
        if (boundary) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (boundary && stop_last) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame configuration and parity are frozen here so mid-frame changes wait for the next frame.
    if (transfer) begin
      state_d  = S_START;
      smp_d    = 4'd0;
      tx_d     = 1'b0;
      shift_d  = hold_q;
      bit8_d   = bit8_i;
      par_en_d = parity_en_i;
      par_d    = (^(hold_q & par_mask)) ^ odd_n_even_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      smp_q       <= 4'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      fifo_rd_q   <= 1'b0;
      tx_q        <= 1'b1;
      bit8_q      <= 1'b0;
      par_en_q    <= 1'b0;
      par_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      smp_q       <= smp_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      fifo_rd_q   <= fifo_rd_d;
      tx_q        <= tx_d;
      bit8_q      <= bit8_d;
      par_en_q    <= par_en_d;
      par_q       <= par_d;
    end
  end

  assign fifo_rd_o = fifo_rd_q;
  assign txrdy_o   = (TX_FIFO != 0) ? !fifo_empty_i : !hold_full_q;
  assign tx_busy_o = (state_q != S_IDLE);
  assign tx_o      = tx_q;

endmodule

// File: tb/tb_uart_tx_async.sv
// Self-checking bench for uart_tx_async: holding-register instance plus an external-FIFO instance.
module tb_uart_tx_async;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_en = 1'b0;
  logic       bit8 = 1'b1, parity_en = 1'b0, odd_n_even = 1'b0, stop2 = 1'b0;
  logic       wen = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd, txrdy, tx_busy, tx;

  logic       f_wen = 1'b0, f_stop2 = 1'b0;
  logic [7:0] f_data = 8'h00;
  logic       f_fifo_empty = 1'b1;
  logic       f_fifo_rd, f_txrdy, f_tx_busy, f_tx;

  int nvec = 0;
  int nerr = 0;
  int f_rd_cnt = 0;
  int sel = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  uart_tx_async #(.TX_FIFO(0)) dut (
    .clk(clk), .rst_n(rst_n), .baud_en_i(baud_en),
    .bit8_i(bit8), .parity_en_i(parity_en), .odd_n_even_i(odd_n_even),
`ifdef UART_TX_TWO_STOP_EN
    .stop2_i(stop2),
`endif
    .wen_i(wen), .data_in_i(data_in), .fifo_empty_i(fifo_empty),
    .fifo_rd_o(fifo_rd), .txrdy_o(txrdy), .tx_busy_o(tx_busy), .tx_o(tx)
  );

  uart_tx_async #(.TX_FIFO(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .baud_en_i(baud_en),
    .bit8_i(bit8), .parity_en_i(parity_en), .odd_n_even_i(odd_n_even),
`ifdef UART_TX_TWO_STOP_EN
    .stop2_i(f_stop2),
`endif
    .wen_i(f_wen), .data_in_i(f_data), .fifo_empty_i(f_fifo_empty),
    .fifo_rd_o(f_fifo_rd), .txrdy_o(f_txrdy), .tx_busy_o(f_tx_busy), .tx_o(f_tx)
  );

  always @(negedge clk) if (f_fifo_rd) f_rd_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference frame: the list of line levels, one entry per bit time.
  function automatic void add_frame(input logic [7:0] d, input bit b8, input bit pen,
                                    input bit odd, input bit s2);
    int n = b8 ? 8 : 7;
    int ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (pen) exp_q.push_back(((ones % 2) == 1) != odd);
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
  endfunction

  task automatic cycle(input logic b);
    @(negedge clk);
    baud_en = b;
    @(posedge clk);
    #1;
  endtask

  task automatic baud_step();
    repeat ($urandom_range(0, 2)) cycle(1'b0);
    cycle(1'b1);
    baud_en = 1'b0;
  endtask

  task automatic write(input logic [7:0] d);
    @(negedge clk);
    baud_en = 1'b0;
    wen = 1'b1;
    data_in = d;
    @(posedge clk);
    #1;
    wen = 1'b0;
  endtask

  function automatic logic cur_tx();
    return (sel != 0) ? f_tx : tx;
  endfunction

  function automatic logic cur_busy();
    return (sel != 0) ? f_tx_busy : tx_busy;
  endfunction

  // Sample j is taken after the j-th enable counted from the transfer edge; it carries bit j/16.
  task automatic run_stream(input int from, input int to);
    for (int j = from; j < to; j++) begin
      baud_step();
      chk($sformatf("tx s%0d", j), cur_tx(), exp_q[j / 16]);
      chk($sformatf("busy s%0d", j), cur_busy(), 1'b1);
    end
  endtask

  task automatic end_idle();
    baud_step();
    chk("idle tx", cur_tx(), 1'b1);
    chk("idle busy", cur_busy(), 1'b0);
  endtask

  task automatic set_cfg(input bit b8, input bit pen, input bit odd, input bit s2);
    @(negedge clk);
    bit8 = b8; parity_en = pen; odd_n_even = odd;
`ifdef UART_TX_TWO_STOP_EN
    stop2 = s2;
`endif
  endtask

  task automatic directed_frame(input logic [7:0] d, input bit b8, input bit pen, input bit odd);
    set_cfg(b8, pen, odd, 1'b0);
    exp_q.delete();
    add_frame(d, b8, pen, odd, 1'b0);
    write(d);
    chk("txrdy after write", txrdy, 1'b0);
    run_stream(0, exp_q.size() * 16);
    end_idle();
    chk("txrdy frame end", txrdy, 1'b1);
  endtask

  initial begin
    logic [7:0] d;
    bit b8, pen, odd, s2;
    logic held;
    int stall_at;

    repeat (3) @(posedge clk);
    #1;
    chk("rst tx", tx, 1'b1);
    chk("rst txrdy", txrdy, 1'b1);
    chk("rst busy", tx_busy, 1'b0);
    chk("rst fifo_rd", fifo_rd, 1'b0);
    chk("rst f_tx", f_tx, 1'b1);
    chk("rst f_fifo_rd", f_fifo_rd, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 8N1 0x55, 7E1 0x41 (bit 7 not sent), 8O1 0xA5
    directed_frame(8'h55, 1'b1, 1'b0, 1'b0);
    directed_frame(8'hC1, 1'b0, 1'b1, 1'b0);
    directed_frame(8'hA5, 1'b1, 1'b1, 1'b1);

    // Back-to-back frames, third write dropped while the hold is full
    set_cfg(1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.delete();
    add_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
    add_frame(8'h34, 1'b1, 1'b0, 1'b0, 1'b0);
    write(8'h12);
    run_stream(0, 1);
    chk("b2b txrdy free", txrdy, 1'b1);
    write(8'h34);
    chk("b2b txrdy full", txrdy, 1'b0);
    write(8'h56);
    chk("b2b txrdy still full", txrdy, 1'b0);
    run_stream(1, exp_q.size() * 16);
    end_idle();

    // Randomised frames; config inputs scrambled after the transfer, plus a baud stall
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      b8 = 1'($urandom); pen = 1'($urandom); odd = 1'($urandom);
`ifdef UART_TX_TWO_STOP_EN
      s2 = 1'($urandom);
`else
      s2 = 1'b0;
`endif
      set_cfg(b8, pen, odd, s2);
      exp_q.delete();
      add_frame(d, b8, pen, odd, s2);
      write(d);
      run_stream(0, 1);
      set_cfg(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      stall_at = $urandom_range(1, exp_q.size() * 16 - 2);
      run_stream(1, stall_at);
      held = tx;
      repeat (30) cycle(1'b0);
      chk("stall tx", tx, held);
      chk("stall busy", tx_busy, 1'b1);
      run_stream(stall_at, exp_q.size() * 16);
      end_idle();
    end

    // Reset during data bit 3, then a clean frame
    set_cfg(1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.delete();
    add_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    write(8'hC3);
    run_stream(0, 16 * 4 + 5);
    chk("pre-reset tx", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort tx", tx, 1'b1);
    chk("abort txrdy", txrdy, 1'b1);
    chk("abort busy", tx_busy, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    directed_frame(8'h3C, 1'b1, 1'b0, 1'b0);

    // External FIFO mode
    sel = 1;
    set_cfg(1'b1, 1'b0, 1'b0, 1'b0);
    chk("fifo txrdy empty", f_txrdy, 1'b0);
    @(negedge clk);
    f_fifo_empty = 1'b0;
    f_data = 8'h7E;
    #1;
    chk("fifo txrdy avail", f_txrdy, 1'b1);
    @(posedge clk);
    #1;
    chk("fifo_rd pulse", f_fifo_rd, 1'b1);
    cycle(1'b0);
    chk("fifo_rd one clk", f_fifo_rd, 1'b0);
    f_rd_cnt = 0;
    exp_q.delete();
    add_frame(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);
    run_stream(0, exp_q.size() * 16);
    chk("fifo no extra rd", f_rd_cnt, 0);
    @(negedge clk);
    f_fifo_empty = 1'b1;
    end_idle();
    chk("fifo main idle", tx_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_tx_async.md
Name: uart_tx_async

Overview:
- Asynchronous UART transmitter. It is the transmit-side counterpart of the receiver in the same core.
- Serialises one character per frame: start bit, 7 or 8 data bits LSB-first, optional parity, one stop bit.
- Bit timing comes from the shared 16x baud enable, so each bit lasts 16 enable pulses.
- Sits between the APB register file (holding-register writes, or an external TX FIFO) and the TX pad.

Parameters:
- TX_FIFO, 0: 0 = internal holding register loaded by WEN; 1 = characters are pulled from an external FIFO via FIFO_EMPTY/FIFO_RD.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- BAUD_EN  in  1  one-CLK pulse at 16x the baud rate.
- BIT8  in  1  1 = 8 data bits, 0 = 7 data bits.
- PARITY_EN  in  1  1 = parity bit inserted.
- ODD_N_EVEN  in  1  1 = odd parity, 0 = even parity.
- WEN  in  1  holding-register write strobe (TX_FIFO=0 only).
- DATA_IN  in  8  character to send (holding-register data or FIFO read data).
- FIFO_EMPTY  in  1  external FIFO empty flag (TX_FIFO=1 only).
- FIFO_RD  out  1  one-CLK FIFO pop strobe (TX_FIFO=1; tied 0 otherwise).
- TXRDY  out  1  holding register empty, a write is accepted.
- TX_BUSY  out  1  frame in progress.
- TX  out  1  serial output, idle high.

Behaviour:
- Reset: TX=1, TXRDY=1, TX_BUSY=0, FIFO_RD=0. State IDLE, hold register empty, all counters 0.
- Reset asserted mid-frame aborts the frame immediately. TX returns to 1 asynchronously.
- States: IDLE, START, DATA, PARITY, STOP.
- A 4-bit sample counter increments on each BAUD_EN while not IDLE. Bit boundary is counter = 15 with BAUD_EN; the counter wraps to 0 there.
- Holding register (TX_FIFO=0):
  - WEN while TXRDY=1 loads DATA_IN. TXRDY goes 0 on the next edge.
  - WEN while TXRDY=0 is ignored; the held data is unchanged.
- Transfer: in IDLE with hold full, on the next BAUD_EN the following happen on the same edge:
  - hold copies into the shift register;
  - BIT8, PARITY_EN and ODD_N_EVEN are latched for the whole frame;
  - TXRDY returns to 1, TX_BUSY goes to 1, TX goes to 0, state moves to START.
  - A new WEN is therefore accepted during a frame, giving back-to-back frames with no idle gap.
- TX_FIFO=1 sequencing:
  - In IDLE with FIFO_EMPTY=0, FIFO_RD pulses for exactly one CLK.
  - DATA_IN is captured into the hold on the following CLK.
  - Transfer then proceeds as above. TXRDY mirrors ~FIFO_EMPTY.
  - FIFO_RD is never asserted while the hold is full.
- START -> DATA after 16 BAUD_EN. TX carries the data LSB first, shifting one bit per bit boundary.
- DATA -> PARITY or STOP after 8 bits (BIT8=1) or 7 bits (BIT8=0).
- Parity is the XOR of the transmitted data bits, inverted when ODD_N_EVEN=1. The 8th bit is excluded when BIT8=0.
- STOP drives TX=1 for 16 BAUD_EN, then:
  - goes to IDLE with TX_BUSY=0 if the hold is empty;
  - otherwise transfers directly into START on the same boundary.
- TX is registered, so there are no glitches. Configuration changes mid-frame take effect from the next frame only.
- BAUD_EN held low stalls the frame indefinitely with TX stable.

Optional Feature:
- Macro UART_TX_TWO_STOP_EN.
- Defined: adds input STOP2. When STOP2=1, the STOP state lasts 32 BAUD_EN (two stop bits); STOP2 is latched at frame start.
- Undefined: no STOP2 port; always one stop bit (16 BAUD_EN).

Test Plan:
- 8N1, write 0x55 -> TX sequence 0,1,0,1,0,1,0,1,0,1. Each bit lasts 16 BAUD_EN; 160 BAUD_EN total. TX_BUSY=0 after the stop bit.
- 7E1, write 0x41 -> start, data 1,0,0,0,0,0,1, parity 0, stop 1 (10 bits). Bit 7 of DATA_IN is not sent.
- 8O1, write 0xA5 -> data 1,0,1,0,0,1,0,1, parity 1, stop 1.
- Write 0x12, then 0x34 once TXRDY=1 during frame 1, then a third write while TXRDY=0 -> two contiguous frames (0x12, 0x34) with no idle bit between them. The third write is dropped.
- TX_FIFO=1, FIFO_EMPTY falls with 0x7E at the FIFO head -> single FIFO_RD pulse, then frame 0x7E. No second FIFO_RD until the hold empties.
- RESET_N low at data bit 3 -> TX=1 immediately, TXRDY=1, TX_BUSY=0. The next write sends a clean full frame.
